// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl
// Main control FSM for a multi-cycle LEGv8 core. Moves one instruction at a
// time through fetch/decode/execute/memory/write-back over a shared ALU and a
// single shared memory port. It also counts retired instructions and traps on
// opcodes it does not decode.
module legv8_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      op_code,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg2loc,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BR_CBZ, S_BR_B, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    OP_RTYPE, OP_LDUR, OP_STUR, OP_CBZ, OP_B, OP_ILL
  } op_class_t;

  // Map the 11-bit opcode field onto the instruction classes the FSM handles.
  function automatic op_class_t classify(input logic [10:0] op);
    op_class_t cls;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) begin
      cls = OP_RTYPE;
    end else if (op == 11'b11111000010) begin
      cls = OP_LDUR;
    end else if (op == 11'b11111000000) begin
      cls = OP_STUR;
    end else if (op[10:3] == 8'b10110100) begin
      cls = OP_CBZ;
    end else if (op[10:5] == 6'b000101) begin
      cls = OP_B;
    end else begin
      cls = OP_ILL;
    end
    return cls;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  op_class_t        op_class_s;
  logic [CNT_W-1:0] retired_r;

  assign op_class_s = classify(op_code);
  assign retired    = retired_r;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_RST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= {CNT_W{1'b0}};
    end else if (instr_done) begin
      retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_r <= retired_r;
    end
  end

  // Next-state and Moore strobes; mem_ready/zero only gate the few
  // outputs that complete a handshake or a conditional branch.
  always_comb begin
    state_nxt_s = state_r;
    ALUOp       = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    reg2loc     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state_r)
      S_RST: begin
        state_nxt_s = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        reg2loc   = (op_class_s == OP_CBZ) || (op_class_s == OP_STUR);
        case (op_class_s)
          OP_RTYPE: state_nxt_s = S_EXEC_R;
          OP_LDUR:  state_nxt_s = S_MEM_ADDR;
          OP_STUR:  state_nxt_s = S_MEM_ADDR;
          OP_CBZ:   state_nxt_s = S_BR_CBZ;
          OP_B:     state_nxt_s = S_BR_B;
          default:  state_nxt_s = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        ALUOp       = 2'b10;
        state_nxt_s = S_R_WB;
      end
      S_R_WB: begin
        reg_write   = 1'b1;
        instr_done  = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        reg2loc   = (op_class_s == OP_STUR);
        if (op_class_s == OP_STUR) begin
          state_nxt_s = S_MEM_WR;
        end else begin
          state_nxt_s = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_nxt_s = S_MEM_WB;
        end else begin
          state_nxt_s = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        reg_write   = 1'b1;
        mem_to_reg  = 1'b1;
        instr_done  = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        reg2loc   = 1'b1;
        if (mem_ready) begin
          instr_done  = 1'b1;
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEM_WR;
        end
      end
      S_BR_CBZ: begin
        alu_src_a   = 1'b1;
        ALUOp       = 2'b01;
        reg2loc     = 1'b1;
        pc_src      = 1'b1;
        pc_write    = zero;
        instr_done  = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_BR_B: begin
        pc_src      = 1'b1;
        pc_write    = 1'b1;
        instr_done  = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_TRAP: begin
        illegal     = 1'b1;
        state_nxt_s = S_TRAP;
      end
      default: begin
        state_nxt_s = S_RST;
      end
    endcase
  end

endmodule
